note_scheduler: RTL

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_pkg.sv | 19 +
 rtl/voice_timer.sv | 43 ++++
 rtl/note_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared defaults and the per-voice state record for the note scheduler.
package note_pkg;

    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_NOTE_W     = 4;
    localparam int DEF_DUR_W      = 8;

    // Age rank is two bits wide, so at most four voices can be ranked distinctly.
    localparam int RANK_W = 2;

    // One voice as seen by the allocator: active flag, note, remaining ticks, age rank.
    typedef struct packed {
        logic                  on;
        logic [DEF_NOTE_W-1:0] note;
        logic [DEF_DUR_W-1:0]  count;
        logic [RANK_W-1:0]     rank;
    } voice_state_t;

endpackage

// File: rtl/voice_timer.sv
// Remaining-tick counter for one voice: loads a duration, counts down on tick
// and drops its active flag on the edge where the count reaches zero.
module voice_timer
    import note_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    output logic             on,
    output logic [DUR_W-1:0] count,
    output logic             ending
);

    logic             on_reg;
    logic [DUR_W-1:0] count_reg;

    // Load wins over the countdown so a reloaded voice keeps its full length.
    always_ff @(posedge clk) begin
        if (rst) begin
            on_reg    <= 1'b0;
            count_reg <= '0;
        end else if (load) begin
            on_reg    <= 1'b1;
            count_reg <= load_val;
        end else if (tick && on_reg) begin
            count_reg <= count_reg - 1'b1;
            if (count_reg == DUR_W'(1)) begin
                on_reg <= 1'b0;
            end
        end
    end

    assign on     = on_reg;
    assign count  = count_reg;
    // High in the cycle whose edge will expire this voice; the allocator
    // treats such a voice as already free.
    assign ending = on_reg && tick && (count_reg == DUR_W'(1));

endmodule

// File: rtl/note_scheduler.sv
// Polyphonic note scheduler: assigns incoming note requests to voice lanes,
// retriggering a matching voice, else using a free one, else stealing the oldest.
module note_scheduler
    import note_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic [NOTE_W-1:0]            note_code,
    input  logic [DUR_W-1:0]             note_dur,
    output logic [NUM_VOICES-1:0]        voice_on,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_start,
    output logic                         steal
);

    logic [NUM_VOICES-1:0] on_w;
    logic [NUM_VOICES-1:0] ending_w;
    logic [DUR_W-1:0]      count_w [NUM_VOICES];

    logic [NOTE_W-1:0]     note_reg  [NUM_VOICES];
    logic [RANK_W-1:0]     rank_reg  [NUM_VOICES];
    logic [RANK_W-1:0]     rank_next [NUM_VOICES];
    logic [NUM_VOICES-1:0] start_reg;
    logic                  steal_reg;

    logic [NUM_VOICES-1:0] tgt;
    logic                  stealing;
    logic                  accept_load;
    logic [NUM_VOICES-1:0] load_vec;
    logic [NUM_VOICES-1:0] survive;

    // Ready simply mirrors reset so it is high in every out-of-reset cycle,
    // including the first one after release.
    assign note_ready  = ~rst;
    assign accept_load = note_valid && note_ready && (note_dur != '0);
    assign load_vec    = accept_load ? tgt : '0;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            voice_timer #(.DUR_W(DUR_W)) u_timer (
                .clk      (clk),
                .rst      (rst),
                .tick     (tick),
                .load     (load_vec[gi]),
                .load_val (note_dur),
                .on       (on_w[gi]),
                .count    (count_w[gi]),
                .ending   (ending_w[gi])
            );
            // Voices that stay active past this edge and are not being reloaded.
            assign survive[gi] = on_w[gi] && !ending_w[gi] && !load_vec[gi];
            assign voice_note[gi*NOTE_W +: NOTE_W] = note_reg[gi];
        end
    endgenerate

    // Target selection: retrigger match, then lowest free voice, then oldest.
    always_comb begin
        logic              found;
        logic [RANK_W-1:0] best;
        tgt      = '0;
        stealing = 1'b0;
        found    = 1'b0;
        best     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && on_w[i] && (note_reg[i] == note_code)) begin
                tgt   = NUM_VOICES'(1) << i;
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && (!on_w[i] || ending_w[i])) begin
                tgt   = NUM_VOICES'(1) << i;
                found = 1'b1;
            end
        end
        if (!found) begin
            stealing = 1'b1;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (on_w[i] && (!found || (rank_reg[i] >= best))) begin
                    tgt   = NUM_VOICES'(1) << i;
                    best  = rank_reg[i];
                    found = 1'b1;
                end
            end
        end
    end

    // New rank = number of younger survivors, plus one if a voice is loaded
    // this edge (it becomes the youngest). This both ages the others on a
    // load and closes any gaps left by expiring voices.
    always_comb begin
        int younger;
        younger = 0;
        for (int j = 0; j < NUM_VOICES; j++) begin
            rank_next[j] = '0;
        end
        for (int j = 0; j < NUM_VOICES; j++) begin
            younger = 0;
            for (int k = 0; k < NUM_VOICES; k++) begin
                if (survive[k] && (rank_reg[k] < rank_reg[j])) begin
                    younger = younger + 1;
                end
            end
            if (survive[j]) begin
                rank_next[j] = RANK_W'(younger + (accept_load ? 1 : 0));
            end
        end
    end

    // Note, rank and pulse registers; note is held while a voice is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= '0;
                rank_reg[i] <= '0;
            end
            start_reg <= '0;
            steal_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_vec[i]) begin
                    note_reg[i] <= note_code;
                end
                rank_reg[i] <= rank_next[i];
            end
            start_reg <= load_vec;
            steal_reg <= accept_load && stealing;
        end
    end

    assign voice_on    = on_w;
    assign voice_start = start_reg;
    assign steal       = steal_reg;

endmodule
